// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, write-source encoding and scoreboard helper for the
// register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_P    = 2'd1,
        SRC_Q    = 2'd2,
        SRC_M    = 2'd3
    } wbSrc_e;

    // One-hot mask for a register index; r0 never owns a scoreboard bit.
    function automatic logic [NREG-1:0] regMask(input logic [AW-1:0] r);
        logic [NREG-1:0] m;
        m    = {{(NREG-1){1'b0}}, 1'b1} << r;
        m[0] = 1'b0;
        return m;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_wb_result_fifo.sv
// Small queue holding mult/div results that lost the register-file write port.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                   clock,
    input  logic                   ctrl_reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] rdPtr_r;
    logic [PW-1:0] wrPtr_r;
    logic [CW-1:0] count_r;

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rdPtr_r <= '0;
            wrPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (push) wrPtr_r <= wrPtr_r + PW'(1);
            if (pop)  rdPtr_r <= rdPtr_r + PW'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (push) begin
            mem_r[wrPtr_r] <= din;
        end
    end

    assign head  = mem_r[rdPtr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and the
// mult/div unit, and tracks registers with outstanding mult/div results.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = regfile_wb_arbiter_pkg::AW,
    parameter int DW    = regfile_wb_arbiter_pkg::DW
) (
    input  logic          clock,
    input  logic          ctrl_reset_n,
    input  logic          p_we,
    input  logic [AW-1:0] p_reg,
    input  logic [DW-1:0] p_data,
    input  logic          m_valid,
    input  logic [AW-1:0] m_reg,
    input  logic [DW-1:0] m_data,
    output logic          m_ready,
    input  logic          md_issue,
    input  logic [AW-1:0] md_rd,
    input  logic [AW-1:0] dec_rs1,
    input  logic [AW-1:0] dec_rs2,
    input  logic [AW-1:0] dec_rd,
    output logic          dec_stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_reg,
    output logic [DW-1:0] rf_data,
    output logic [31:0]   busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    wbSrc_e         wbSrc_s;
    logic [AW+DW-1:0] qHead_s;
    logic [CW-1:0]  qCount_s;
    logic           qFull_s;
    logic           qEmpty_s;
    logic           qPush_s;
    logic           qPop_s;
    logic           mAccept_s;
    logic [31:0]    setMask_s;
    logic [31:0]    clrMask_s;
    logic [31:0]    busy_r;

    wb_result_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) uFifo (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .push         (qPush_s),
        .pop          (qPop_s),
        .din          ({m_reg, m_data}),
        .head         (qHead_s),
        .count        (qCount_s),
        .full         (qFull_s),
        .empty        (qEmpty_s)
    );

    // Write-port arbitration: pipeline first, then queued results, then the bypass.
    always_comb begin
        wbSrc_s = SRC_NONE;
        rf_we   = 1'b0;
        rf_reg  = REG_ZERO;
        rf_data = '0;
        if (!ctrl_reset_n) begin
            wbSrc_s = SRC_NONE;
        end else if (p_we && (p_reg != REG_ZERO)) begin
            wbSrc_s = SRC_P;
            rf_we   = 1'b1;
            rf_reg  = p_reg;
            rf_data = p_data;
        end else if (!qEmpty_s) begin
            wbSrc_s = SRC_Q;
            rf_we   = 1'b1;
            rf_reg  = qHead_s[AW+DW-1:DW];
            rf_data = qHead_s[DW-1:0];
        end else if (m_valid && (m_reg != REG_ZERO)) begin
            wbSrc_s = SRC_M;
            rf_we   = 1'b1;
            rf_reg  = m_reg;
            rf_data = m_data;
        end else begin
            wbSrc_s = SRC_NONE;
        end
    end

    // Readiness comes from registered occupancy only, so a full queue refuses even while popping.
    assign m_ready   = (qCount_s < CW'(DEPTH));
    assign mAccept_s = m_valid & m_ready;
    assign qPush_s   = mAccept_s && (m_reg != REG_ZERO) && (wbSrc_s != SRC_M) && !qFull_s;
    assign qPop_s    = (wbSrc_s == SRC_Q);

    // Scoreboard set/clear masks; pipeline writes never retire a pending result.
    always_comb begin
        setMask_s = '0;
        clrMask_s = '0;
        if ((wbSrc_s == SRC_Q) || (wbSrc_s == SRC_M)) begin
            clrMask_s = regMask(rf_reg);
        end else begin
            clrMask_s = '0;
        end
        if (md_issue) begin
            setMask_s = regMask(md_rd);
        end else begin
            setMask_s = '0;
        end
    end

    // Busy vector; a same-edge issue beats the completing write.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= (busy_r & ~clrMask_s) | setMask_s;
        end
    end

    assign busy      = busy_r;
    assign dec_stall = busy_r[dec_rs1] | busy_r[dec_rs2] | busy_r[dec_rd];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic          p_we;
    logic [AW-1:0] p_reg;
    logic [DW-1:0] p_data;
    logic          m_valid;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          md_issue;
    logic [AW-1:0] md_rd;
    logic [AW-1:0] dec_rs1;
    logic [AW-1:0] dec_rs2;
    logic [AW-1:0] dec_rd;
    logic          dec_stall;
    logic          rf_we;
    logic [AW-1:0] rf_reg;
    logic [DW-1:0] rf_data;
    logic [31:0]   busy;

    int errors = 0;
    int checks = 0;

    // Reference model: pending results in acceptance order plus a busy bit array.
    logic [AW-1:0] mdlReg[$];
    logic [DW-1:0] mdlData[$];
    logic [31:0]   mdlBusy;
    wbSrc_e        expSrc;
    logic          expWe;
    logic          expReady;
    logic          expStall;
    logic          mdlAccepted;
    logic [AW-1:0] expReg;
    logic [DW-1:0] expData;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .p_we         (p_we),
        .p_reg        (p_reg),
        .p_data       (p_data),
        .m_valid      (m_valid),
        .m_reg        (m_reg),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .md_issue     (md_issue),
        .md_rd        (md_rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .dec_stall    (dec_stall),
        .rf_we        (rf_we),
        .rf_reg       (rf_reg),
        .rf_data      (rf_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic setIdle();
        p_we = 1'b0; p_reg = 5'd0; p_data = 32'd0;
        m_valid = 1'b0; m_reg = 5'd0; m_data = 32'd0;
        md_issue = 1'b0; md_rd = 5'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
    endtask

    task automatic modelPredict();
        expReady = (mdlReg.size() < DEPTH);
        expSrc   = SRC_NONE;
        expReg   = 5'd0;
        expData  = 32'd0;
        if (p_we && p_reg != 5'd0) begin
            expSrc = SRC_P; expReg = p_reg; expData = p_data;
        end else if (mdlReg.size() != 0) begin
            expSrc = SRC_Q; expReg = mdlReg[0]; expData = mdlData[0];
        end else if (m_valid && m_reg != 5'd0) begin
            expSrc = SRC_M; expReg = m_reg; expData = m_data;
        end
        expWe    = (expSrc != SRC_NONE);
        expStall = mdlBusy[dec_rs1] | mdlBusy[dec_rs2] | mdlBusy[dec_rd];
    endtask

    task automatic modelCommit();
        mdlAccepted = m_valid && expReady;
        if (expSrc == SRC_Q) begin
            void'(mdlReg.pop_front());
            void'(mdlData.pop_front());
        end
        if (expSrc == SRC_Q || expSrc == SRC_M) mdlBusy[expReg] = 1'b0;
        if (mdlAccepted && m_reg != 5'd0 && expSrc != SRC_M) begin
            mdlReg.push_back(m_reg);
            mdlData.push_back(m_data);
        end
        if (md_issue && md_rd != 5'd0) mdlBusy[md_rd] = 1'b1;
    endtask

    task automatic tick();
        modelPredict();
        @(posedge clock);
        modelCommit();
        #1;
    endtask

    task automatic applyReset();
        ctrl_reset_n = 1'b0;
        setIdle();
        mdlReg.delete();
        mdlData.delete();
        mdlBusy = 32'd0;
        @(posedge clock);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ctrl_reset_n = 1'b0;
        setIdle();
        p_we = 1'b1; p_reg = 5'd3; m_valid = 1'b1; m_reg = 5'd4;
        #3;
        checks++;
        if ({rf_we, m_ready, dec_stall, busy} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b rdy=%0b stall=%0b busy=%h want 0 1 0 0", rf_we, m_ready, dec_stall, busy);
        end
        applyReset();
        @(negedge clock);
        checks++;
        if ({rf_we, m_ready, busy} !== {1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL reset_release: got we=%0b rdy=%0b busy=%h want 0 1 0", rf_we, m_ready, busy);
        end
    endtask

    task automatic test_bypass();
        applyReset();
        md_issue = 1'b1; md_rd = 5'd5;
        tick();
        md_issue = 1'b0;
        m_valid = 1'b1; m_reg = 5'd5; m_data = 32'hDEADBEEF; dec_rs1 = 5'd5;
        @(negedge clock);
        checks++;
        if ({rf_we, rf_reg, rf_data, dec_stall} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            errors++;
            $display("FAIL bypass_write: got we=%0b reg=%0d data=%h stall=%0b want 1 5 deadbeef 1", rf_we, rf_reg, rf_data, dec_stall);
        end
        tick();
        m_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({rf_we, m_ready, dec_stall, busy} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL bypass_after: got we=%0b rdy=%0b stall=%0b busy=%h want 0 1 0 0", rf_we, m_ready, dec_stall, busy);
        end
    endtask

    task automatic test_collision();
        applyReset();
        md_issue = 1'b1; md_rd = 5'd7;
        tick();
        md_issue = 1'b0; dec_rs1 = 5'd7;
        tick();
        tick();
        p_we = 1'b1; p_reg = 5'd3; p_data = 32'hA5A50003;
        m_valid = 1'b1; m_reg = 5'd7; m_data = 32'h11;
        @(negedge clock);
        checks++;
        if ({rf_we, rf_reg, rf_data, m_ready, dec_stall} !== {1'b1, 5'd3, 32'hA5A50003, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL collide_p: got we=%0b reg=%0d data=%h rdy=%0b stall=%0b want 1 3 a5a50003 1 1", rf_we, rf_reg, rf_data, m_ready, dec_stall);
        end
        tick();
        p_we = 1'b0; m_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({rf_we, rf_reg, rf_data, dec_stall} !== {1'b1, 5'd7, 32'h11, 1'b1}) begin
            errors++;
            $display("FAIL collide_q: got we=%0b reg=%0d data=%h stall=%0b want 1 7 11 1", rf_we, rf_reg, rf_data, dec_stall);
        end
        tick();
        @(negedge clock);
        checks++;
        if ({rf_we, dec_stall, busy} !== {1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL collide_done: got we=%0b stall=%0b busy=%h want 0 0 0", rf_we, dec_stall, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] regs [3];
        logic [DW-1:0] vals [3];
        regs = '{5'd10, 5'd11, 5'd13};
        vals = '{32'h100, 32'h101, 32'h102};
        applyReset();
        p_we = 1'b1; p_reg = 5'd9; p_data = 32'h9;
        for (int c = 0; c < 4; c++) begin
            m_valid = 1'b1;
            m_reg = regs[(c < 2) ? c : 2];
            m_data = vals[(c < 2) ? c : 2];
            @(negedge clock);
            checks++;
            if ({rf_we, rf_reg, m_ready} !== {1'b1, 5'd9, (c < 2) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL bp_fill%0d: got we=%0b reg=%0d rdy=%0b want 1 9 %0b", c, rf_we, rf_reg, m_ready, (c < 2));
            end
            tick();
        end
        p_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({rf_we, rf_reg, rf_data} !== {1'b1, regs[c], vals[c]}) begin
                errors++;
                $display("FAIL bp_drain%0d: got we=%0b reg=%0d data=%h want 1 %0d %h", c, rf_we, rf_reg, rf_data, regs[c], vals[c]);
            end
            tick();
            if (c == 1) m_valid = 1'b0;
        end
        @(negedge clock);
        checks++;
        if ({rf_we, m_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bp_empty: got we=%0b rdy=%0b want 0 1", rf_we, m_ready);
        end
    endtask

    task automatic test_reg_zero();
        applyReset();
        p_we = 1'b1; p_reg = 5'd9; m_valid = 1'b1; m_reg = 5'd4; m_data = 32'h44;
        tick();
        p_reg = 5'd0; p_data = 32'hBAD; m_valid = 1'b0; md_issue = 1'b1; md_rd = 5'd0;
        @(negedge clock);
        checks++;
        if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd4, 32'h44}) begin
            errors++;
            $display("FAIL r0_pwrite: got we=%0b reg=%0d data=%h want 1 4 44", rf_we, rf_reg, rf_data);
        end
        tick();
        setIdle();
        @(negedge clock);
        checks++;
        if ({rf_we, busy} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL r0_issue: got we=%0b busy=%h want 0 0", rf_we, busy);
        end
        m_valid = 1'b1; m_reg = 5'd0; m_data = 32'h55;
        @(negedge clock);
        checks++;
        if ({rf_we, m_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL r0_mvalid: got we=%0b rdy=%0b want 0 1", rf_we, m_ready);
        end
        tick();
        m_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({rf_we, m_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL r0_discard: got we=%0b rdy=%0b want 0 1", rf_we, m_ready);
        end
    endtask

    task automatic test_set_clear();
        applyReset();
        p_we = 1'b1; p_reg = 5'd9; m_valid = 1'b1; m_reg = 5'd12; m_data = 32'hC;
        tick();
        p_we = 1'b0; m_valid = 1'b0; md_issue = 1'b1; md_rd = 5'd12;
        @(negedge clock);
        checks++;
        if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd12, 32'hC}) begin
            errors++;
            $display("FAIL setclr_write: got we=%0b reg=%0d data=%h want 1 12 c", rf_we, rf_reg, rf_data);
        end
        tick();
        md_issue = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 32'h0000_1000) begin
            errors++;
            $display("FAIL setclr_busy: got busy=%h want 00001000", busy);
        end
    endtask

    task automatic test_async_reset();
        applyReset();
        md_issue = 1'b1; md_rd = 5'd7;
        tick();
        md_rd = 5'd12;
        tick();
        md_issue = 1'b0;
        p_we = 1'b1; p_reg = 5'd9; m_valid = 1'b1; m_reg = 5'd20; m_data = 32'h20;
        tick();
        m_reg = 5'd21; m_data = 32'h21;
        tick();
        m_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, m_ready} !== {32'h0000_1080, 1'b0}) begin
            errors++;
            $display("FAIL areset_setup: got busy=%h rdy=%0b want 00001080 0", busy, m_ready);
        end
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        checks++;
        if ({rf_we, busy, m_ready} !== {1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL areset_now: got we=%0b busy=%h rdy=%0b want 0 0 1", rf_we, busy, m_ready);
        end
        setIdle();
        mdlReg.delete();
        mdlData.delete();
        mdlBusy = 32'd0;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({rf_we, m_ready} !== {1'b0, 1'b1}) begin
                errors++;
                $display("FAIL areset_stale%0d: got we=%0b rdy=%0b want 0 1", c, rf_we, m_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic          holdM;
        logic [AW-1:0] obsReg;
        logic [DW-1:0] obsData;
        applyReset();
        holdM = 1'b0;
        for (int i = 0; i < 400; i++) begin
            p_we   = ($urandom_range(0, 9) < 4);
            p_reg  = AW'($urandom_range(0, 31));
            p_data = $urandom();
            if (!holdM) begin
                m_valid = ($urandom_range(0, 9) < 5);
                m_reg   = AW'($urandom_range(0, 31));
                for (int k = 0; k < 6; k++) begin
                    if (!mdlBusy[m_reg]) m_reg = AW'($urandom_range(0, 31));
                end
                m_data = $urandom();
            end
            md_rd    = AW'($urandom_range(0, 31));
            md_issue = ($urandom_range(0, 9) < 3) && !mdlBusy[md_rd];
            dec_rs1  = AW'($urandom_range(0, 31));
            dec_rs2  = AW'($urandom_range(0, 31));
            dec_rd   = AW'($urandom_range(0, 31));
            @(negedge clock);
            modelPredict();
            obsReg  = expWe ? rf_reg : 5'd0;
            obsData = expWe ? rf_data : 32'd0;
            checks++;
            if ({rf_we, obsReg, obsData, m_ready, dec_stall, busy} !==
                {expWe, expReg, expData, expReady, expStall, mdlBusy}) begin
                errors++;
                $display("FAIL random_c%0d: got we=%0b reg=%0d data=%h rdy=%0b stall=%0b busy=%h want we=%0b reg=%0d data=%h rdy=%0b stall=%0b busy=%h",
                         i, rf_we, obsReg, obsData, m_ready, dec_stall, busy,
                         expWe, expReg, expData, expReady, expStall, mdlBusy);
            end
            tick();
            holdM = m_valid && !mdlAccepted;
        end
        setIdle();
    endtask

    initial begin
        setIdle();
        ctrl_reset_n = 1'b0;
        mdlBusy = 32'd0;
        test_reset();
        test_bypass();
        test_collision();
        test_backpressure();
        test_reg_zero();
        test_set_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
